// File: rtl/dpwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpwm_pkg
//  Description : Shared types and constants for the DPWM display path
//                (BCD conversion controller state encoding, digit count,
//                double-dabble add-3 threshold).
//  Revision    : 1.0  initial release
// ============================================================================
package dpwm_pkg;

    // Conversion controller state encoding
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of BCD digits produced by the converter
    localparam int BCD_DIGITS = 4;

    // A BCD nibble at or above this value is corrected by +3 before shifting
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage : dpwm_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Combinational double-dabble nibble correction:
//                o_nibble = (i_nibble >= 5) ? i_nibble + 3 : i_nibble
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_add3
    import dpwm_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    // Pre-shift correction so the nibble carries correctly into the next digit
    always_comb begin
        o_nibble = i_nibble;
        if (i_nibble >= ADD3_THRESH) begin
            o_nibble = i_nibble + 4'd3;
        end
    end

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bcd_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_conv_ctrl
//  Description : Sequential binary-to-BCD converter (shift-add-3) with
//                explicit or periodic start, registered digit outputs,
//                busy flag and one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_conv_ctrl
    import dpwm_pkg::*;
#(
    parameter int N_BITS  = 10,
    parameter int REFRESH = 1000
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] N_Binario,
    input  logic              Inicio,
    input  logic              Auto,
    output logic [3:0]        Millares,
    output logic [3:0]        Centenas,
    output logic [3:0]        Decenas,
    output logic [3:0]        Unidades,
    output logic              Ocupado,
    output logic              Listo
);

    localparam int c_BCD_W = 4 * BCD_DIGITS;
    localparam int c_SR_W  = c_BCD_W + N_BITS;
    localparam int c_CNT_W = $clog2(N_BITS + 1);
    localparam int c_REF_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(N_BITS - 1);
    localparam logic [c_REF_W-1:0] c_REF_MAX = c_REF_W'(REFRESH - 1);

    state_t               r_state;
    logic [c_SR_W-1:0]    r_sr;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_REF_W-1:0]   r_ref_cnt;
    logic                 r_pend;
    logic [3:0]           r_millares;
    logic [3:0]           r_centenas;
    logic [3:0]           r_decenas;
    logic [3:0]           r_unidades;
    logic                 r_ocupado;
    logic                 r_listo;

    logic [c_SR_W-1:0]    w_adj;
    logic [c_SR_W-1:0]    w_shift;
    logic                 w_auto_tick;
    logic                 w_req;

    // Binary part passes through untouched; every BCD nibble gets its add-3 check
    assign w_adj[N_BITS-1:0] = r_sr[N_BITS-1:0];

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .i_nibble (r_sr [N_BITS + 4*gi +: 4]),
                .o_nibble (w_adj[N_BITS + 4*gi +: 4])
            );
        end
    endgenerate

    assign w_shift     = w_adj << 1;
    assign w_auto_tick = Auto && (r_ref_cnt == c_REF_MAX);
    assign w_req       = Inicio || r_pend || w_auto_tick;

    // Free-running refresh divider, active only while periodic mode is on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_cnt <= '0;
        end else if (!Auto || w_auto_tick) begin
            r_ref_cnt <= '0;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    // Conversion FSM: capture, N_BITS shift-add-3 steps, publish digits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_pend     <= 1'b0;
            r_millares <= 4'd0;
            r_centenas <= 4'd0;
            r_decenas  <= 4'd0;
            r_unidades <= 4'd0;
            r_ocupado  <= 1'b0;
            r_listo    <= 1'b0;
        end else begin
            r_listo <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_sr      <= {{c_BCD_W{1'b0}}, N_Binario};
                        r_bit_cnt <= '0;
                        r_ocupado <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr      <= w_shift;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_LAST) begin
                        r_millares <= w_shift[c_SR_W-1  -: 4];
                        r_centenas <= w_shift[c_SR_W-5  -: 4];
                        r_decenas  <= w_shift[c_SR_W-9  -: 4];
                        r_unidades <= w_shift[c_SR_W-13 -: 4];
                        r_listo    <= 1'b1;
                        r_ocupado  <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
            endcase

            // A refresh tick that lands mid-conversion is remembered once;
            // leaving periodic mode drops any remembered tick.
            if (!Auto) begin
                r_pend <= 1'b0;
            end else if (r_state == SHIFT && w_auto_tick) begin
                r_pend <= 1'b1;
            end else if (r_state == IDLE && w_req) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign Millares = r_millares;
    assign Centenas = r_centenas;
    assign Decenas  = r_decenas;
    assign Unidades = r_unidades;
    assign Ocupado  = r_ocupado;
    assign Listo    = r_listo;

endmodule : bcd_conv_ctrl
`default_nettype wire

// File: tb/tb_bcd_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_conv_ctrl
//  Description : Scoreboard bench for bcd_conv_ctrl. Stimulus pushes the
//                expected digits, per-instance monitors pop on Listo.
//                Instance A: REFRESH=16, instance B: REFRESH=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_conv_ctrl;

    logic       clk = 1'b0;
    logic       reset;

    logic [9:0] n_a, n_b;
    logic       inicio_a, inicio_b, auto_a, auto_b;
    logic [3:0] mil_a, cen_a, dec_a, uni_a;
    logic [3:0] mil_b, cen_b, dec_b, uni_b;
    logic       ocup_a, ocup_b, listo_a, listo_b;

    int         n_vec = 0;
    int         n_err = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] exp_a, exp_b;

    always #5 clk = ~clk;

    bcd_conv_ctrl #(.N_BITS(10), .REFRESH(16)) dut_a (
        .clk(clk), .reset(reset), .N_Binario(n_a), .Inicio(inicio_a), .Auto(auto_a),
        .Millares(mil_a), .Centenas(cen_a), .Decenas(dec_a), .Unidades(uni_a),
        .Ocupado(ocup_a), .Listo(listo_a)
    );

    bcd_conv_ctrl #(.N_BITS(10), .REFRESH(4)) dut_b (
        .clk(clk), .reset(reset), .N_Binario(n_b), .Inicio(inicio_b), .Auto(auto_b),
        .Millares(mil_b), .Centenas(cen_b), .Decenas(dec_b), .Unidades(uni_b),
        .Ocupado(ocup_b), .Listo(listo_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, instance A
    always @(negedge clk) begin
        if (!reset && listo_a) begin
            if (q_a.size() == 0) begin
                chk("A unexpected Listo", 1, 0);
            end else begin
                exp_a = q_a.pop_front();
                chk("A digits", int'({mil_a, cen_a, dec_a, uni_a}), int'(exp_a));
            end
        end
    end

    // Scoreboard monitor, instance B
    always @(negedge clk) begin
        if (!reset && listo_b) begin
            if (q_b.size() == 0) begin
                chk("B unexpected Listo", 1, 0);
            end else begin
                exp_b = q_b.pop_front();
                chk("B digits", int'({mil_b, cen_b, dec_b, uni_b}), int'(exp_b));
            end
        end
    end

    task automatic wait_listo_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!listo_a && n < 100);
    endtask

    task automatic wait_listo_b(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!listo_b && n < 100);
    endtask

    task automatic quiet_a(input int cycles, input string name);
        int cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (listo_a) cnt++;
        end
        chk(name, cnt, 0);
    endtask

    task automatic quiet_b(input int cycles, input string name);
        int cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (listo_b) cnt++;
        end
        chk(name, cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int busy;
        reset    = 1'b1;
        n_a      = '0;
        n_b      = '0;
        inicio_a = 1'b0;
        inicio_b = 1'b0;
        auto_a   = 1'b0;
        auto_b   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset digits", int'({mil_a, cen_a, dec_a, uni_a}), 0);
        chk("reset Ocupado", int'(ocup_a), 0);
        chk("reset Listo", int'(listo_a), 0);
        reset = 1'b0;
        @(negedge clk);

        // T1: single conversion of 924, latency and busy window
        n_a = 10'd924; inicio_a = 1'b1; q_a.push_back(16'h0924);
        @(negedge clk);
        inicio_a = 1'b0;
        chk("T1 Ocupado after start", int'(ocup_a), 1);
        busy = 0;
        repeat (9) begin
            @(negedge clk);
            if (ocup_a && !listo_a) busy++;
        end
        chk("T1 busy cycles", busy, 9);
        @(negedge clk);
        chk("T1 Listo at cycle 11", int'(listo_a), 1);
        chk("T1 Ocupado low with Listo", int'(ocup_a), 0);
        @(negedge clk);
        chk("T1 Listo one cycle", int'(listo_a), 0);

        // T2: back-to-back 1023 then 0 with Inicio held through Listo
        n_a = 10'd1023; inicio_a = 1'b1; q_a.push_back(16'h1023);
        @(negedge clk);
        n_a = 10'd0; q_a.push_back(16'h0000);
        wait_listo_a(n);
        chk("T2 first latency", n, 10);
        @(negedge clk);
        inicio_a = 1'b0;
        chk("T2 no gap Ocupado", int'(ocup_a), 1);
        chk("T2 Listo dropped", int'(listo_a), 0);
        wait_listo_a(n);
        chk("T2 second spacing-1", n, 10);
        @(negedge clk);

        // T3: Inicio re-pulsed and input changed mid-conversion
        n_a = 10'd234; inicio_a = 1'b1; q_a.push_back(16'h0234);
        @(negedge clk);
        inicio_a = 1'b0;
        repeat (3) @(negedge clk);
        inicio_a = 1'b1; n_a = 10'd1;
        @(negedge clk);
        inicio_a = 1'b0;
        wait_listo_a(n);
        chk("T3 latency unaffected", n, 6);
        quiet_a(20, "T3 no second conversion");
        chk("T3 idle Ocupado", int'(ocup_a), 0);

        // T4: reset in the middle of converting 1000
        n_a = 10'd1000; inicio_a = 1'b1;
        @(negedge clk);
        inicio_a = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("T4 reset digits", int'({mil_a, cen_a, dec_a, uni_a}), 0);
        chk("T4 reset Ocupado", int'(ocup_a), 0);
        chk("T4 reset Listo", int'(listo_a), 0);
        @(negedge clk);
        reset = 1'b0;
        quiet_a(15, "T4 aborted conversion silent");
        chk("T4 Ocupado after abort", int'(ocup_a), 0);
        n_a = 10'd1; inicio_a = 1'b1; q_a.push_back(16'h0001);
        @(negedge clk);
        inicio_a = 1'b0;
        wait_listo_a(n);
        chk("T4 restart latency", n, 10);

        // T5: periodic mode, REFRESH=16
        @(negedge clk);
        n_a = 10'd512; auto_a = 1'b1;
        repeat (3) q_a.push_back(16'h0512);
        wait_listo_a(n);
        chk("T5 first auto Listo", n, 26);
        wait_listo_a(n);
        chk("T5 auto period 1", n, 16);
        wait_listo_a(n);
        chk("T5 auto period 2", n, 16);
        auto_a = 1'b0;
        quiet_a(40, "T5 no Listo after Auto=0");

        // T6: periodic mode shorter than a conversion, REFRESH=4
        n_b = 10'd345; auto_b = 1'b1;
        repeat (6) q_b.push_back(16'h0345);
        wait_listo_b(n);
        chk("T6 first auto Listo", n, 14);
        for (int i = 0; i < 4; i++) begin
            wait_listo_b(n);
            chk("T6 back-to-back period", n, 11);
        end
        repeat (3) @(negedge clk);
        auto_b = 1'b0;
        wait_listo_b(n);
        chk("T6 in-flight conversion completes", n, 8);
        quiet_b(30, "T6 pending dropped by Auto=0");

        chk("A scoreboard drained", q_a.size(), 0);
        chk("B scoreboard drained", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bcd_conv_ctrl
`default_nettype wire

// File: doc/bcd_conv_ctrl.md
Name: bcd_conv_ctrl

Overview:
- Sequential controller for binary-to-BCD conversion in the DPWM display path; replaces the combinational converter where timing or area is tight.
- Captures a binary value (duty/period readout), runs an iterative shift-add-3 (double-dabble) sequence, and presents registered thousands/hundreds/tens/units digits with a done pulse.
- Conversions start on an explicit request or automatically at a fixed refresh rate for the display scanner.

Parameters:
- N_BITS, 10, width of binary input; legal range 4..13 so the result fits in 4 BCD digits (max 8191).
- REFRESH, 1000, clock cycles between automatic conversions when Auto=1; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- N_Binario  in  N_BITS  binary value, sampled only on conversion start.
- Inicio  in  1  start request, level-sampled in IDLE.
- Auto  in  1  enables periodic self-start every REFRESH cycles.
- Millares  out  4  BCD thousands digit, registered.
- Centenas  out  4  BCD hundreds digit, registered.
- Decenas  out  4  BCD tens digit, registered.
- Unidades  out  4  BCD units digit, registered.
- Ocupado  out  1  high while a conversion is in progress.
- Listo  out  1  one-cycle pulse when new digits are valid.

Behaviour:
- Reset (async, any time including mid-conversion) sets state IDLE, all digits 0, Ocupado 0, Listo 0, the refresh counter 0 and the pending flag 0. The partial shift register is discarded.
- FSM states: IDLE, SHIFT.
- IDLE -> SHIFT on an edge where `req = Inicio | pend | auto_tick`:
  - load the shift register with {16'b0, N_Binario} and set the bit counter to 0;
  - Ocupado <= 1; pend <= 0.
- SHIFT, one bit per edge:
  - first, each 4-bit BCD field >= 5 gets +3;
  - then the whole register shifts left by 1;
  - the counter increments.
- On the edge performing shift N_BITS:
  - the digit outputs load the adjusted and shifted BCD fields;
  - Listo <= 1, Ocupado <= 0, state <= IDLE.
- Latency: start sampled at edge k; Listo is high during the cycle after edge k+N_BITS (11 cycles for N_BITS=10). Listo is high for exactly one cycle.
- Digits are held between conversions. Intermediate values are never visible on the outputs.
- Back-to-back: if req is asserted in the cycle Listo is high, the FSM is already in IDLE and the next conversion starts at that edge. No idle bubble.
- Inicio during SHIFT is ignored and not queued.
- Auto mode:
  - While Auto=1 the refresh counter counts 0..REFRESH-1 and wraps. auto_tick is high for one cycle at count REFRESH-1.
  - If auto_tick occurs during SHIFT, pend is set and the conversion starts on the first IDLE edge.
  - Auto=0 clears the counter and pend synchronously.
  - Inicio and auto_tick in the same IDLE cycle produce a single conversion.
- Width rule: the BCD register is 16 bits, and the adjust compare/add is per nibble on all 4 nibbles every shift cycle. No overflow flag is needed within the legal N_BITS range.

Decomposition:
- Shared package dpwm_pkg holds the FSM state encodings (IDLE=1'b0, SHIFT=1'b1), BCD_DIGITS=4, and the add-3 threshold constant 4'd5.
- One natural sub-module, bcd_add3: a 4-bit combinational nibble adjust (in >= 5 ? in+3 : in), instantiated 4x.
- The refresh counter and FSM stay in the top module.

Test Plan:
- reset, then N_Binario=924, Inicio pulse 1 cycle -> Ocupado high for 10 cycles; Listo pulses at cycle 11; digits 0,9,2,4.
- N_Binario=1023 then N_Binario=0, back-to-back starts (Inicio held through Listo) -> digits 1,0,2,3 then 0,0,0,0; second Listo exactly 11 cycles after the first; no gap cycle.
- Conversion of 234 running, then Inicio re-pulsed and N_Binario changed to 1 at cycle 5 -> result still 0,2,3,4; no second conversion starts.
- Conversion of 1000 with reset asserted at cycle 6 and released -> all digits 0, Ocupado 0, no Listo; a following start with 1 yields 0,0,0,1.
- REFRESH=16, Auto=1, N_Binario=512 -> Listo pulses every 16 cycles with digits 0,5,1,2; Auto=0 -> no further Listo.
- REFRESH=4 (shorter than the conversion), Auto=1 -> each auto_tick arriving during SHIFT is held pending; conversions run back-to-back, one Listo per conversion, no lost or duplicated starts.
